// File: rtl/sequencer_pkg.sv
// ----------------------------------------------------------------------------
// sequencer_pkg : state and opcode definitions for multicycle_sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sequencer_pkg;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } seq_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // SYSTEM is deliberately absent: it halts cleanly rather than as illegal.
  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_exec_op = 1'b1;
      default:                           is_exec_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// ----------------------------------------------------------------------------
// wait_timer : counts stalled memory cycles, flags expiry on the LIMIT-th one
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expires on the cycle that would bring the count to LIMIT.
  assign expired = inc && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer : FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_sequencer
  import sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_load,
  output logic                  pc_en,
  output logic                  reg_we,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_error,
  output logic [DATA_WIDTH-1:0] instret
);

  seq_state_t state, state_next;
  logic [6:0] opcode;
  logic       waiting;
  logic       expired;
  logic       set_illegal;
  logic       set_bus_error;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[DATA_WIDTH-1:7];
  assign waiting           = (state == S_FETCH) || (state == S_MEMORY);

  // Cleared on any completion or outside the memory states, so each
  // FETCH/MEMORY visit starts counting from zero.
  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!waiting || mem_ready),
    .inc     (waiting && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_START;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
      instret   <= '0;
    end else begin
      state <= state_next;
      if (set_illegal)   illegal   <= 1'b1;
      if (set_bus_error) bus_error <= 1'b1;
      if (pc_en)         instret   <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    reg_we        = 1'b0;
    halted        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    case (state)
      S_START: state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (expired) begin
          set_bus_error = 1'b1;
          state_next    = S_HALT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_next = S_HALT;
        end else if (!is_exec_op(opcode)) begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_next = S_MEMORY;
        end else if (opcode == OP_BRANCH) begin
          pc_en      = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = MemWrite;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_en      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (expired) begin
          set_bus_error = 1'b1;
          state_next    = S_HALT;
        end
      end
      S_WRITEBACK: begin
        reg_we     = RegWrite;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  halted     = 1'b1;
      default: state_next = S_START;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_sequencer : cycle-by-cycle check against an instruction-level
// timing model, plus literal checks on key latencies and flags
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_sequencer;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] instr = '0;
  logic          RegWrite = 1'b0;
  logic          MemWrite = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_load, pc_en, reg_we;
  logic          halted, illegal, bus_error;
  logic [DW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.DATA_WIDTH(DW), .MEM_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_load   (ir_load),
    .pc_en     (pc_en),
    .reg_we    (reg_we),
    .halted    (halted),
    .illegal   (illegal),
    .bus_error (bus_error),
    .instret   (instret)
  );

  // One entry per clock: inputs to apply and outputs expected that cycle.
  // flags = {mem_req, mem_we, addr_sel, ir_load, pc_en, reg_we, halted, illegal, bus_error}
  typedef struct {
    logic          rst_n;
    logic [DW-1:0] instr;
    logic          rw;
    logic          mw;
    logic          rdy;
    logic [8:0]    flags;
    logic [DW-1:0] ret;
  } rec_t;

  rec_t          q[$];
  int            tests = 0;
  int            fails = 0;
  int            start_idx = 0;
  int            m_ret;
  bit            m_halt, m_ill, m_berr;
  logic [DW-1:0] cur_instr = '0;
  bit            cur_rw, cur_mw;
  int            o_irl_first, o_rwe_first, o_rwe_cnt, o_as_cnt, o_we_cnt;
  int            o_halt_first, o_req_halted;

  function automatic void push(bit rdy, bit req, bit we, bit as, bit irl, bit pce, bit rwe);
    rec_t r;
    r.rst_n = 1'b1;
    r.instr = cur_instr;
    r.rw    = cur_rw;
    r.mw    = cur_mw;
    r.rdy   = rdy;
    r.flags = {req, we, as, irl, pce, rwe, m_halt, m_ill, m_berr};
    r.ret   = DW'(m_ret);
    q.push_back(r);
    if (pce) m_ret++;
  endfunction

  // mem_ready is randomised wherever it must be ignored.
  function automatic void push_idle();
    push(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void do_reset();
    rec_t r;
    m_ret = 0; m_halt = 0; m_ill = 0; m_berr = 0;
    r.rst_n = 1'b0; r.instr = '0; r.rw = 1'b0; r.mw = 1'b0; r.rdy = 1'b1;
    r.flags = '0; r.ret = '0;
    q.push_back(r);
    q.push_back(r);
    start_idx = q.size();
    push_idle();
  endfunction

  // Instruction-level model: fetch waits fw, memory waits mw.
  function automatic void gen(input logic [DW-1:0] ins, input int fw, input int mw);
    logic [6:0] op;
    bit ld, st, br, sys, known;
    if (m_halt) return;
    op        = ins[6:0];
    cur_instr = ins;
    ld    = (op == 7'h03);
    st    = (op == 7'h23);
    br    = (op == 7'h63);
    sys   = (op == 7'h73);
    known = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    cur_rw = !(st || br);
    cur_mw = st;
    for (int k = 0; k < fw && k < TO; k++) push(0, 1, 0, 0, 0, 0, 0);
    if (fw >= TO) begin m_halt = 1; m_berr = 1; return; end
    push(1, 1, 0, 0, 1, 0, 0);
    push_idle();
    if (sys) begin m_halt = 1; return; end
    if (!known) begin m_halt = 1; m_ill = 1; return; end
    push(1'($urandom_range(0, 1)), 0, 0, 0, 0, br, 0);
    if (br) return;
    if (ld || st) begin
      for (int k = 0; k < mw && k < TO; k++) push(0, 1, st, 1, 0, 0, 0);
      if (mw >= TO) begin m_halt = 1; m_berr = 1; return; end
      push(1, 1, st, 1, 0, st, 0);
      if (st) return;
    end
    push(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1, cur_rw);
  endfunction

  function automatic void gen_halt(input int n);
    for (int k = 0; k < n; k++) push_idle();
  endfunction

  task automatic run();
    logic [8:0] got;
    int idx;
    o_irl_first = -1; o_rwe_first = -1; o_halt_first = -1;
    o_rwe_cnt = 0; o_as_cnt = 0; o_we_cnt = 0; o_req_halted = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n     = q[i].rst_n;
      instr     = q[i].instr;
      RegWrite  = q[i].rw;
      MemWrite  = q[i].mw;
      mem_ready = q[i].rdy;
      @(negedge clk);
      got = {mem_req, mem_we, addr_sel, ir_load, pc_en, reg_we, halted, illegal, bus_error};
      tests++;
      if (got !== q[i].flags || instret !== q[i].ret) begin
        fails++;
        $display("FAIL cycle[%0d] outputs: got flags=%b instret=%0d, expected flags=%b instret=%0d",
                 i - start_idx, got, instret, q[i].flags, q[i].ret);
      end
      idx = i - start_idx;
      if (idx >= 0) begin
        if (ir_load && o_irl_first < 0) o_irl_first = idx;
        if (reg_we && o_rwe_first < 0) o_rwe_first = idx;
        if (halted && o_halt_first < 0) o_halt_first = idx;
        if (reg_we)   o_rwe_cnt++;
        if (addr_sel) o_as_cnt++;
        if (mem_we)   o_we_cnt++;
        if (halted && mem_req) o_req_halted++;
      end
    end
    q.delete();
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // addi with zero-wait memory
    do_reset(); gen(32'h00500093, 0, 0); run(); settle();
    check("addi ir_load cycle", o_irl_first, 1);
    check("addi reg_we cycle", o_rwe_first, 4);
    check("addi instret", int'(instret), 1);

    // lw with two memory wait states
    do_reset(); gen(32'h0000A103, 0, 2); run(); settle();
    check("lw addr_sel cycles", o_as_cnt, 3);
    check("lw reg_we cycle", o_rwe_first, 7);
    check("lw instret", int'(instret), 1);

    // sw then beq
    do_reset(); gen(32'h0020A023, 0, 0); gen(32'h00000063, 0, 0); run(); settle();
    check("sw/beq reg_we count", o_rwe_cnt, 0);
    check("sw/beq mem_we count", o_we_cnt, 1);
    check("sw/beq instret", int'(instret), 2);

    // illegal opcode, then ecall
    do_reset(); gen(32'h0000007F, 0, 0); gen_halt(4); run();
    check("illegal halt cycle", o_halt_first, 3);
    check("illegal flag", int'(illegal), 1);
    check("illegal mem_req while halted", o_req_halted, 0);
    do_reset(); gen(32'h00000073, 0, 0); gen_halt(4); run();
    check("ecall halt cycle", o_halt_first, 3);
    check("ecall illegal flag", int'(illegal), 0);
    check("ecall halted", int'(halted), 1);

    // fetch timeout, then reset restarts from START
    do_reset(); gen(32'h00500093, 20, 0); gen_halt(3); run();
    check("fetch timeout halt cycle", o_halt_first, 16);
    check("fetch timeout bus_error", int'(bus_error), 1);
    do_reset(); gen(32'h00500093, 0, 0); run();
    check("restart ir_load cycle", o_irl_first, 1);

    // mixed program with waits, including ready on the last allowed cycle
    do_reset();
    gen(32'h002081B3, 1, 0);
    gen(32'h0000006F, 14, 0);
    gen(32'h12345237, 0, 0);
    gen(32'h00000297, 3, 0);
    gen(32'h000080E7, 0, 0);
    gen(32'h0020A023, 0, 14);
    gen(32'h0000A103, 2, 3);
    gen(32'h00000063, 0, 0);
    gen(32'h0000A103, 0, 15);
    gen_halt(3);
    run();
    check("mixed instret", int'(instret), 8);
    check("memory timeout bus_error", int'(bus_error), 1);

    // reset asserted mid-MEMORY
    do_reset(); gen(32'h0000A103, 0, 10);
    while (q.size() > start_idx + 7) void'(q.pop_back());
    do_reset(); gen(32'h00500093, 0, 0); run(); settle();
    check("mid-op reset restart ir_load", o_irl_first, 1);
    check("mid-op reset instret", int'(instret), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
